regfile_write_arbiter: RTL

//  Shares the single register-file write port (PW/RW/LE) between two writeback

---
 rtl/regfile_write_arbiter.sv | 103 ++++++++++
 1 files changed

// File: rtl/regfile_write_arbiter.sv
// Two-requester arbiter for the single register-file write port. It registers the
// winning write, discards writes to r0, and raises hazard flags for in-flight writes.
module regfile_write_arbiter #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int MAX_WAIT = 3,
  parameter int CNT_W    = 2
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              a_req,
  input  logic [ADDR_W-1:0] a_rw,
  input  logic [DATA_W-1:0] a_pw,
  output logic              a_gnt,
  input  logic              b_req,
  input  logic [ADDR_W-1:0] b_rw,
  input  logic [DATA_W-1:0] b_pw,
  output logic              b_gnt,
  input  logic [ADDR_W-1:0] q_ra,
  input  logic [ADDR_W-1:0] q_rb,
  input  logic [ADDR_W-1:0] q_rd,
  output logic [DATA_W-1:0] rf_pw,
  output logic [ADDR_W-1:0] rf_rw,
  output logic              rf_le,
  output logic [2:0]        hz
);

  typedef enum logic {A_PRI, B_PRI} state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] rw;
    logic [DATA_W-1:0] pw;
  } wr_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] wait_cnt, wait_nxt;
  wr_t              win;
  logic             any_gnt;

  // Priority only matters under contention; a lone requester always wins.
  always_comb begin
    a_gnt = 1'b0;
    b_gnt = 1'b0;
    if (!Reset) begin
      if (a_req && b_req) begin
        if (state == B_PRI) b_gnt = 1'b1;
        else                a_gnt = 1'b1;
      end else begin
        a_gnt = a_req;
        b_gnt = b_req;
      end
    end
  end

  assign any_gnt = a_gnt | b_gnt;
  assign win     = b_gnt ? wr_t'{rw: b_rw, pw: b_pw} : wr_t'{rw: a_rw, pw: a_pw};

  // Flip to B priority on the edge where the loss count reaches MAX_WAIT.
  always_comb begin
    wait_nxt  = '0;
    state_nxt = state;
    if (b_req && !b_gnt)
      wait_nxt = (wait_cnt == {CNT_W{1'b1}}) ? wait_cnt : wait_cnt + 1'b1;
    case (state)
      A_PRI:   if (wait_nxt >= CNT_W'(MAX_WAIT)) state_nxt = B_PRI;
      B_PRI:   if (b_gnt) state_nxt = A_PRI;
      default: state_nxt = A_PRI;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state    <= A_PRI;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
    end
  end

  // A granted r0 write is consumed but never enables the port.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      rf_le <= 1'b0;
      rf_rw <= '0;
      rf_pw <= '0;
    end else if (any_gnt) begin
      rf_le <= (win.rw != '0);
      rf_rw <= win.rw;
      rf_pw <= win.pw;
    end else begin
      rf_le <= 1'b0;
    end
  end

  logic [2:0][ADDR_W-1:0] q;
  assign q = {q_rd, q_rb, q_ra};

  for (genvar i = 0; i < 3; i++) begin : g_hz
    assign hz[i] = rf_le && (rf_rw == q[i]) && (q[i] != '0);
  end

endmodule
